data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 153 +++++++++++++++
 tb/tb_data_cache.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16 lines of 4 words.
// A single FSM handles CPU lookups and the writeback/fill traffic to backing memory.
module data_cache #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req_valid,
  input  logic         cpu_req_we,
  input  logic [31:0]  cpu_req_addr,
  input  logic [31:0]  cpu_req_wdata,
  output logic         cpu_req_ready,
  output logic         cpu_resp_valid,
  output logic [31:0]  cpu_resp_rdata,
  output logic         mem_req_valid,
  output logic         mem_req_we,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_wdata,
  input  logic         mem_req_ready,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_rdata,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int LINE_BITS = LINE_WORDS * 32;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, WB_WAIT, FILL, FILL_WAIT} state_t;

  state_t state, state_next;

  logic [NUM_SETS-1:0]  valid_bits;
  logic [NUM_SETS-1:0]  dirty_bits;
  logic [23:0]          tag_arr  [NUM_SETS];
  logic [LINE_BITS-1:0] data_arr [NUM_SETS];

  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        refill;

  logic [3:0]  idx;
  logic [23:0] req_tag;
  logic [6:0]  word_lsb;
  logic        hit;
  logic        unused_bits;

  assign idx         = req_addr[7:4];
  assign req_tag     = req_addr[31:8];
  assign word_lsb    = {req_addr[3:2], 5'b0};
  assign hit         = valid_bits[idx] && (tag_arr[idx] == req_tag);
  assign unused_bits = ^req_addr[1:0];

  always_comb begin
    state_next     = state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = 32'd0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = 32'd0;
    mem_req_wdata  = '0;
    case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_rdata = data_arr[idx][word_lsb +: 32];
          state_next     = IDLE;
        end else if (dirty_bits[idx] && valid_bits[idx]) begin
          state_next = WRITEBACK;
        end else begin
          state_next = FILL;
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_arr[idx], idx, 4'b0};
        mem_req_wdata = data_arr[idx];
        if (mem_req_ready) state_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_resp_valid) state_next = FILL;
      end
      FILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, idx, 4'b0};
        if (mem_req_ready) state_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_resp_valid) state_next = LOOKUP;
      end
      default: state_next = IDLE;
    endcase
  end

  // The refill flag marks the re-lookup after a fill so it is not counted as a second hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      valid_bits <= '0;
      dirty_bits <= '0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
      refill     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_we    <= cpu_req_we;
            req_addr  <= cpu_req_addr;
            req_wdata <= cpu_req_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (!refill) hit_count <= hit_count + 32'd1;
            refill <= 1'b0;
            if (req_we) dirty_bits[idx] <= 1'b1;
          end else begin
            miss_count <= miss_count + 32'd1;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= 1'b0;
            refill          <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == LOOKUP && hit && req_we)
        data_arr[idx][word_lsb +: 32] <= req_wdata;
      if (state == FILL_WAIT && mem_resp_valid) begin
        data_arr[idx] <= mem_resp_rdata;
        tag_arr[idx]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed CPU requests queue expected load data,
// a negedge monitor checks every cpu_resp_valid pulse against the queue.
module tb_data_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_we;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_wdata;
  logic         cpu_req_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         mem_req_valid;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  localparam logic [127:0] L0  = 128'h0303_0003_0202_0002_DEAD_BEEF_0101_0000;
  localparam logic [127:0] WB1 = 128'h0303_0003_0202_0002_DEAD_BEEF_1234_5678;
  localparam logic [127:0] L1  = 128'hB3B3_0003_B2B2_0002_B1B1_0001_B0B0_1100;
  localparam logic [127:0] L2  = 128'hC3C3_0003_C2C2_0002_C1C1_0001_C0C0_0040;
  localparam logic [127:0] WB2 = 128'hC3C3_0003_C2C2_0002_C1C1_0001_AAAA_5555;
  localparam logic [127:0] L3  = 128'hD3D3_0003_D2D2_0002_D1D1_0001_D0D0_1040;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  data_cache dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset && cpu_resp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("resp_outstanding", 128'(exp_q.size()), 128'd1);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk) checkOutput("resp_rdata", 128'(cpu_resp_rdata), 128'(mon_e.data));
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic push, input logic chk, input logic [31:0] exp);
    int   n = 0;
    exp_t e;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    while (!cpu_req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("cpu_req_ready", 128'(cpu_req_ready), 128'd1);
    if (!cpu_req_ready) begin
      cpu_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    if (push) begin
      e.chk  = chk;
      e.data = exp;
      exp_q.push_back(e);
    end
  endtask

  // Stray mem_resp_valid during the stall cycles must not move the FSM.
  task automatic serveMemory(input logic exp_we, input logic [31:0] exp_addr,
                             input logic [127:0] exp_wdata, input logic chk_wdata,
                             input int delay, input logic do_resp, input logic [127:0] line);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("mem_req_valid", 128'(mem_req_valid), 128'd1);
    if (!mem_req_valid) return;
    for (int i = 0; i <= delay; i++) begin
      checkOutput("mem_req_valid_hold", 128'(mem_req_valid), 128'd1);
      checkOutput("mem_req_we", 128'(mem_req_we), 128'(exp_we));
      checkOutput("mem_req_addr", 128'(mem_req_addr), 128'(exp_addr));
      if (chk_wdata) checkOutput("mem_req_wdata", mem_req_wdata, exp_wdata);
      checkOutput("cpu_req_ready_busy", 128'(cpu_req_ready), 128'd0);
      if (i < delay) begin
        mem_resp_valid = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
      end
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    checkOutput("mem_req_valid_wait", 128'(mem_req_valid), 128'd0);
    if (do_resp) begin
      mem_resp_rdata = line;
      mem_resp_valid = 1'b1;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
    end
  endtask

  task automatic drainQueue();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("resp_drain", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic checkCounters(input logic [31:0] hits, input logic [31:0] misses);
    checkOutput("hit_count", 128'(hit_count), 128'(hits));
    checkOutput("miss_count", 128'(miss_count), 128'(misses));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    cpu_req_valid  = 1'b0;
    cpu_req_we     = 1'b0;
    cpu_req_addr   = 32'd0;
    cpu_req_wdata  = 32'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("reset_ready", 128'(cpu_req_ready), 128'd1);
    checkOutput("reset_resp_valid", 128'(cpu_resp_valid), 128'd0);
    checkOutput("reset_mem_valid", 128'(mem_req_valid), 128'd0);
    checkCounters(32'd0, 32'd0);

    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    checkOutput("idle_resp_ignored", 128'(cpu_req_ready), 128'd1);

    $display("[TB] cold load miss");
    applyStimulus(1'b0, 32'h0000_0104, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    serveMemory(1'b0, 32'h0000_0100, '0, 1'b0, 2, 1'b1, L0);
    drainQueue();
    checkCounters(32'd0, 32'd1);

    $display("[TB] load hit latency");
    applyStimulus(1'b0, 32'h0000_0108, 32'd0, 1'b1, 1'b1, 32'h0202_0002);
    checkOutput("hit_latency", 128'(cpu_resp_valid), 128'd1);
    checkOutput("hit_no_mem", 128'(mem_req_valid), 128'd0);
    drainQueue();
    checkCounters(32'd1, 32'd1);

    $display("[TB] store hit then conflicting load with stalled writeback");
    applyStimulus(1'b1, 32'h0000_0100, 32'h1234_5678, 1'b1, 1'b0, 32'd0);
    drainQueue();
    applyStimulus(1'b0, 32'h0000_1100, 32'd0, 1'b1, 1'b1, 32'hB0B0_1100);
    serveMemory(1'b1, 32'h0000_0100, WB1, 1'b1, 5, 1'b1, '0);
    serveMemory(1'b0, 32'h0000_1100, '0, 1'b0, 0, 1'b1, L1);
    drainQueue();
    checkCounters(32'd2, 32'd2);

    $display("[TB] store miss allocate then conflicting writeback");
    applyStimulus(1'b1, 32'h0000_0040, 32'hAAAA_5555, 1'b1, 1'b0, 32'd0);
    serveMemory(1'b0, 32'h0000_0040, '0, 1'b0, 0, 1'b1, L2);
    drainQueue();
    checkCounters(32'd2, 32'd3);
    applyStimulus(1'b0, 32'h0000_1040, 32'd0, 1'b1, 1'b1, 32'hD0D0_1040);
    serveMemory(1'b1, 32'h0000_0040, WB2, 1'b1, 1, 1'b1, '0);
    serveMemory(1'b0, 32'h0000_1040, '0, 1'b0, 0, 1'b1, L3);
    drainQueue();
    checkCounters(32'd2, 32'd4);

    $display("[TB] reset during fill wait");
    applyStimulus(1'b0, 32'h0000_0200, 32'd0, 1'b0, 1'b0, 32'd0);
    serveMemory(1'b0, 32'h0000_0200, '0, 1'b0, 0, 1'b0, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checkOutput("abandon_mem_valid", 128'(mem_req_valid), 128'd0);
    mem_resp_rdata = L0;
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    checkOutput("abandon_ready", 128'(cpu_req_ready), 128'd1);
    checkOutput("abandon_no_resp", 128'(cpu_resp_valid), 128'd0);
    checkCounters(32'd0, 32'd0);
    applyStimulus(1'b0, 32'h0000_1100, 32'd0, 1'b1, 1'b1, 32'hB0B0_1100);
    serveMemory(1'b0, 32'h0000_1100, '0, 1'b0, 0, 1'b1, L1);
    drainQueue();
    checkCounters(32'd0, 32'd1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
